alu_cmd_issuer: RTL and testbench

// - Initiator side of the combinational ALU operand interface (a, b, opsel -> result).
// - Accepts ALU commands on a valid/ready stream and drives registered operands/opsel to the ALU.
// - Samples the ALU result after a fixed settle time and queues {op, result, err} in a response FIFO.
// - Returns responses on a valid/ready stream; sits between the command source and the ALU datapath.

---
 rtl/alu_cmd_issuer.sv | 156 +++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - issues ALU commands, samples results after a settle time, queues responses
// Optional: ALU_ISSUER_DIVZERO_CHECK_EN answers op 5 with b==0 locally with an error response.
module alu_cmd_issuer #(
    parameter int WIDTH      = 8,
    parameter int MUL_WIDTH  = 16,
    parameter int SETTLE_CYC = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WIDTH-1:0]     cmd_a,
    input  logic [WIDTH-1:0]     cmd_b,
    input  logic [3:0]           cmd_op,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [3:0]           alu_opsel,
    input  logic [MUL_WIDTH-1:0] alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [MUL_WIDTH-1:0] rsp_data,
    output logic [3:0]           rsp_op,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYC - 1);
    localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]             alu_opsel_q, alu_opsel_d;
    logic [MUL_WIDTH-1:0]   res_mem_q [FIFO_DEPTH];
    logic [MUL_WIDTH-1:0]   res_mem_d [FIFO_DEPTH];
    logic [3:0]             op_mem_q  [FIFO_DEPTH];
    logic [3:0]             op_mem_d  [FIFO_DEPTH];
    logic                   err_mem_q [FIFO_DEPTH];
    logic                   err_mem_d [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]            count_q, count_d;

    logic                   accept, div_zero, push, pop, push_err;
    logic [MUL_WIDTH-1:0]   push_res;
    logic [3:0]             push_op;

    assign cmd_ready = rst_n && (state_q == IDLE) && (count_q != DEPTH_C);
    assign accept    = cmd_valid && cmd_ready;
    assign pop       = (count_q != '0) && rsp_ready;

`ifdef ALU_ISSUER_DIVZERO_CHECK_EN
    assign div_zero = (cmd_op == 4'd5) && (cmd_b == '0);
`else
    assign div_zero = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_opsel_d = alu_opsel_q;
        push        = 1'b0;
        push_res    = '0;
        push_op     = '0;
        push_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && div_zero) begin
                    // Answered locally; the ALU operands are left untouched.
                    push     = 1'b1;
                    push_res = '1;
                    push_op  = 4'd5;
                    push_err = 1'b1;
                end else if (accept) begin
                    alu_a_d     = cmd_a;
                    alu_b_d     = cmd_b;
                    alu_opsel_d = cmd_op;
                    cnt_d       = CNT_INIT;
                    state_d     = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    push     = 1'b1;
                    push_res = alu_result;
                    push_op  = alu_opsel_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Accept requires a free slot, so a push never lands on a full FIFO.
    always_comb begin
        res_mem_d = res_mem_q;
        op_mem_d  = op_mem_q;
        err_mem_d = err_mem_q;
        if (push) begin
            res_mem_d[wr_ptr_q] = push_res;
            op_mem_d[wr_ptr_q]  = push_op;
            err_mem_d[wr_ptr_q] = push_err;
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_opsel_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                res_mem_q[i] <= '0;
                op_mem_q[i]  <= '0;
                err_mem_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_opsel_q <= alu_opsel_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            res_mem_q   <= res_mem_d;
            op_mem_q    <= op_mem_d;
            err_mem_q   <= err_mem_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_opsel = alu_opsel_q;
    assign rsp_valid = (count_q != '0);
    assign rsp_data  = rsp_valid ? res_mem_q[rd_ptr_q] : '0;
    assign rsp_op    = rsp_valid ? op_mem_q[rd_ptr_q]  : '0;
    assign rsp_err   = rsp_valid ? err_mem_q[rd_ptr_q] : 1'b0;
    assign busy      = (state_q != IDLE) || rsp_valid;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - scoreboard bench for alu_cmd_issuer with a behavioural ALU and response model
module tb_alu_cmd_issuer;

    localparam int S = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_a, cmd_b;
    logic [3:0]  cmd_op;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_opsel;
    logic [15:0] alu_result;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_op;
    logic        rsp_err;
    logic        busy;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_mode = 0;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.WIDTH(8), .MUL_WIDTH(16), .SETTLE_CYC(S), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opsel(alu_opsel),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err),
        .busy(busy)
    );

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        int ia = a;
        int ib = b;
        case (op)
            4'd0:    return 16'(ia + ib);
            4'd1:    return 16'(ia - ib);
            4'd2:    return 16'(ia * ib);
            4'd3:    return 16'(ia & ib);
            4'd4:    return 16'(ia | ib);
            4'd5:    return (ib == 0) ? 16'h0000 : 16'(ia / ib);
            4'd6:    return 16'(ia ^ ib);
            default: return 16'((ia * 256 + ib) ^ int'(op));
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_opsel);

    function automatic exp_t make_exp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        exp_t e;
        e.op   = op;
        e.data = alu_f(a, b, op);
        e.err  = 1'b0;
`ifdef ALU_ISSUER_DIVZERO_CHECK_EN
        if (op == 4'd5 && b == 8'd0) begin
            e.data = 16'hFFFF;
            e.err  = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops happen on the next rising edge when valid && ready hold at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual=%0h required=none", rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_op", 32'(rsp_op), 32'(e.op));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        int n = 0;
        bit done = 0;
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        while (!done) begin
            @(negedge clk);
            if (cmd_ready) begin
                exp_q.push_back(make_exp(a, b, op));
                done = 1;
            end else if (n++ > 300) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=cmd_ready=0 required=accept");
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        rand_mode = 0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pa, pb;
        logic [3:0] po;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_opsel", 32'(alu_opsel), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Latency and ready gap for a single add.
        rsp_ready = 1'b1;
        drive_cmd(8'd200, 8'd100, 4'd0);
        chk("issue_alu_a", 32'(alu_a), 32'd200);
        chk("issue_alu_b", 32'(alu_b), 32'd100);
        for (int i = 0; i < S; i++) begin
            @(negedge clk);
            chk("settle_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("settle_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(negedge clk);
        chk("lat_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("lat_rsp_data", 32'(rsp_data), 32'd300);
        chk("lat_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        drive_cmd(8'hFF, 8'hFF, 4'd2);
        wait_drain();

        // Fill the response FIFO with the consumer stalled.
        rsp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) drive_cmd(8'(i), 8'd1, 4'd0);
        repeat (S) @(posedge clk);
        @(negedge clk);
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("full_head", 32'(rsp_data), 32'd2);
        chk("full_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_a = 8'd5;
        cmd_b = 8'd1;
        cmd_op = 4'd0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drive_cmd(8'd5, 8'd1, 4'd0);
        wait_drain();

        // Reset while a command is settling.
        drive_cmd(8'd7, 8'd3, 4'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_cmd(8'd9, 8'd4, 4'd1);
        wait_drain();

        // Divide by zero.
        drive_cmd(8'd12, 8'd3, 4'd6);
        wait_drain();
        pa = 8'd12;
        pb = 8'd3;
        po = 4'd6;
        drive_cmd(8'd9, 8'd0, 4'd5);
`ifdef ALU_ISSUER_DIVZERO_CHECK_EN
        chk("dz_alu_a", 32'(alu_a), 32'(pa));
        chk("dz_alu_b", 32'(alu_b), 32'(pb));
        chk("dz_alu_opsel", 32'(alu_opsel), 32'(po));
`else
        chk("dz_alu_a", 32'(alu_a), 32'd9);
        chk("dz_alu_b", 32'(alu_b), 32'd0);
        chk("dz_alu_opsel", 32'(alu_opsel), 32'd5);
`endif
        wait_drain();

        // Random traffic with a randomly stalling consumer.
        rand_mode = 1;
        for (int i = 0; i < 200; i++) begin
            logic [7:0] ra, rb;
            logic [3:0] ro;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            ro = 4'($urandom_range(0, 15));
            drive_cmd(ra, rb, ro);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
